// File: rtl/alu_op_issuer.sv
// Initiator-side ALU driver: buffers requests in a FIFO, issues each one as a single
// beat or as split A/B beats, then returns the sampled ALU result on a response handshake.
module alu_op_issuer #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int RES_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH-1:0]   req_opa,
  input  logic [DATA_WIDTH-1:0]   req_opb,
  input  logic                    req_mode,
  input  logic [CMD_WIDTH-1:0]    req_cmd,
  input  logic                    req_cin,
  input  logic                    req_split,
  input  logic [3:0]              req_gap,
  output logic                    ce,
  output logic [DATA_WIDTH-1:0]   opa,
  output logic [DATA_WIDTH-1:0]   opb,
  output logic                    mode,
  output logic [1:0]              inp_valid,
  output logic [CMD_WIDTH-1:0]    cmd,
  output logic                    cin,
  input  logic [2*DATA_WIDTH-1:0] res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_res,
  output logic                    busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] LAT_M1 = 3'(RES_LAT - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic                  mode;
    logic [CMD_WIDTH-1:0]  cmd;
    logic                  cin;
    logic                  split;
    logic [3:0]            gap;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_BEAT_A, S_GAP, S_BEAT_B, S_WAIT, S_RESP
  } state_t;

  req_t                  fifo_mem [FIFO_DEPTH];
  req_t                  req_in;
  req_t                  head;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  req_ready_q;
  logic                  fifo_empty;
  logic                  full_d;
  logic                  push;
  logic                  pop;

  state_t                state_q, state_d;
  logic [3:0]            gap_cnt_q;
  logic [2:0]            lat_cnt_q;
  logic [DATA_WIDTH-1:0] hold_opa_q, hold_opb_q;
  logic                  hold_mode_q, hold_cin_q;
  logic [CMD_WIDTH-1:0]  hold_cmd_q;
  logic [3:0]            hold_gap_q;
  logic [2*DATA_WIDTH-1:0] rsp_res_q;

  // ---------------- request FIFO ----------------
  assign req_in     = {req_opa, req_opb, req_mode, req_cmd, req_cin, req_split, req_gap};
  assign push       = req_valid && req_ready_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= req_in;
    end
  end

  // req_ready reflects the occupancy seen at the start of each cycle, so a pop never
  // opens a slot for a push in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_ready_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= !full_d;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = head.split ? S_BEAT_A : S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_WAIT;
      S_BEAT_A: state_d = (hold_gap_q != 4'd0) ? S_GAP : S_BEAT_B;
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_BEAT_B;
        end
      end
      S_BEAT_B: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- holding register, counters, result capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_opa_q  <= '0;
      hold_opb_q  <= '0;
      hold_mode_q <= 1'b0;
      hold_cmd_q  <= '0;
      hold_cin_q  <= 1'b0;
      hold_gap_q  <= '0;
      gap_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      rsp_res_q   <= '0;
    end else begin
      if (pop) begin
        hold_opa_q  <= head.opa;
        hold_opb_q  <= head.opb;
        hold_mode_q <= head.mode;
        hold_cmd_q  <= head.cmd;
        hold_cin_q  <= head.cin;
        hold_gap_q  <= head.gap;
      end

      // GAP lasts gap cycles: load gap-1 on entry, leave when the count reaches zero.
      if (state_q == S_BEAT_A) begin
        gap_cnt_q <= hold_gap_q - 4'd1;
      end else if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q - 4'd1;
      end

      if (state_q != S_WAIT && state_d == S_WAIT) begin
        lat_cnt_q <= LAT_M1;
      end else if (state_q == S_WAIT) begin
        lat_cnt_q <= lat_cnt_q - 3'd1;
      end

      if (state_q == S_WAIT && lat_cnt_q == 3'd0) begin
        rsp_res_q <= res;
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ce        = 1'b0;
    inp_valid = 2'b00;
    opa       = '0;
    opb       = '0;
    mode      = 1'b0;
    cmd       = '0;
    cin       = 1'b0;
    case (state_q)
      S_ISSUE: begin
        ce        = 1'b1;
        inp_valid = 2'b11;
        opa       = hold_opa_q;
        opb       = hold_opb_q;
        mode      = hold_mode_q;
        cmd       = hold_cmd_q;
        cin       = hold_cin_q;
      end
      S_BEAT_A: begin
        ce        = 1'b1;
        inp_valid = 2'b01;
        opa       = hold_opa_q;
        mode      = hold_mode_q;
        cmd       = hold_cmd_q;
        cin       = hold_cin_q;
      end
      S_GAP, S_WAIT: begin
        ce        = 1'b1;
        mode      = hold_mode_q;
        cmd       = hold_cmd_q;
        cin       = hold_cin_q;
      end
      S_BEAT_B: begin
        ce        = 1'b1;
        inp_valid = 2'b10;
        opb       = hold_opb_q;
        mode      = hold_mode_q;
        cmd       = hold_cmd_q;
        cin       = hold_cin_q;
      end
      default: begin
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_res   = rsp_res_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: a reference model predicts the pin trace and result of
// every accepted request; a monitor compares the DUT pins and responses cycle by cycle.
module tb_alu_op_issuer;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          mode;
    logic [CW-1:0] cmd;
    logic          cin;
    logic          split;
    logic [3:0]    gap;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [DW-1:0] req_opa, req_opb;
  logic req_mode, req_cin, req_split;
  logic [CW-1:0] req_cmd;
  logic [3:0] req_gap;
  logic ce, mode, cin;
  logic [DW-1:0] opa, opb;
  logic [1:0] inp_valid;
  logic [CW-1:0] cmd;
  logic [2*DW-1:0] res;
  logic rsp_valid, rsp_ready;
  logic [2*DW-1:0] rsp_res;
  logic busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .FIFO_DEPTH(DEPTH), .RES_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_mode(req_mode), .req_cmd(req_cmd),
    .req_cin(req_cin), .req_split(req_split), .req_gap(req_gap),
    .ce(ce), .opa(opa), .opb(opb), .mode(mode), .inp_valid(inp_valid), .cmd(cmd), .cin(cin),
    .res(res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .busy(busy)
  );

  // Simple ALU stand-in: latches operands on their valid beats, result is combinational.
  function automatic logic [2*DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic m, input logic [CW-1:0] c, input logic ci);
    logic [2*DW-1:0] r;
    if (m && c == '0)
      r = {{DW{1'b0}}, a} + {{DW{1'b0}}, b} + {{(2*DW-1){1'b0}}, ci};
    else if (m)
      r = ({{DW{1'b0}}, a} - {{DW{1'b0}}, b} - {{(2*DW-1){1'b0}}, ci}) ^ {c, {(2*DW-CW){1'b0}}};
    else
      r = {a & b, a | b} ^ {c, {(2*DW-CW){1'b0}}} ^ {{(2*DW-1){1'b0}}, ci};
    return r;
  endfunction

  logic [DW-1:0] a_l = '0, b_l = '0;
  logic [CW-1:0] c_l = '0;
  logic m_l = 1'b0, ci_l = 1'b0;
  always @(posedge clk) begin
    if (ce) begin
      if (inp_valid[0]) a_l <= opa;
      if (inp_valid[1]) b_l <= opb;
      if (inp_valid != 2'b00) begin
        c_l  <= cmd;
        m_l  <= mode;
        ci_l <= cin;
      end
    end
  end
  assign res = alu_f(a_l, b_l, m_l, c_l, ci_l);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard queues filled by the stimulus side on acceptance.
  op_t             trace_q[$];
  logic [2*DW-1:0] res_q[$];

  // ---------------- monitor ----------------
  int   cyc = 0, acc = 0, pops = 0, done = 0, expect_start = -1, k = 0, len = 0;
  bit   in_win = 0, in_resp = 0, prev_ce = 0, prev_rv = 0, prev_rr = 0;
  logic [2*DW-1:0] prev_res = '0, last_rsp = '0;
  op_t  cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        trace_q.delete();
        res_q.delete();
        in_win = 0; in_resp = 0; acc = 0; pops = 0; done = 0; expect_start = -1;
        prev_ce = 0; prev_rv = 0; prev_rr = 0;
      end else begin
        // a rising ce marks the start of a new operation window
        if (ce && !prev_ce) begin
          pops++;
          chk("issue_has_request", 32'(trace_q.size() != 0), 1);
          if (trace_q.size() != 0) begin
            cur = trace_q.pop_front();
            in_win = 1;
            k = 0;
          end
        end
        if (expect_start == cyc) begin
          chk("next_issue_2_after_rsp", 32'(ce), 1);
          expect_start = -1;
        end
        if (in_win) begin
          logic [1:0] eiv;
          logic [DW-1:0] ea, eb;
          len = cur.split ? int'(cur.gap) + 2 : 1;
          if (k < len) begin
            if (!cur.split) begin
              eiv = 2'b11; ea = cur.opa; eb = cur.opb;
            end else if (k == 0) begin
              eiv = 2'b01; ea = cur.opa; eb = '0;
            end else if (k == len - 1) begin
              eiv = 2'b10; ea = '0; eb = cur.opb;
            end else begin
              eiv = 2'b00; ea = '0; eb = '0;
            end
            chk("beat_ce", 32'(ce), 1);
            chk("beat_inp_valid", 32'(inp_valid), 32'(eiv));
            chk("beat_opa", 32'(opa), 32'(ea));
            chk("beat_opb", 32'(opb), 32'(eb));
            chk("beat_cmd", 32'(cmd), 32'(cur.cmd));
            chk("beat_mode", 32'(mode), 32'(cur.mode));
            if (eiv != 2'b00) chk("beat_cin", 32'(cin), 32'(cur.cin));
          end else if (k < len + LAT) begin
            chk("wait_ce", 32'(ce), 1);
            chk("wait_inp_valid", 32'(inp_valid), 0);
          end else begin
            chk("resp_ce_low", 32'(ce), 0);
            chk("resp_valid_on_time", 32'(rsp_valid), 1);
            in_win = 0;
            in_resp = 1;
          end
          k++;
        end
        if (rsp_valid) chk("no_issue_during_resp", 32'(ce), 0);
        if (prev_rv && !prev_rr) begin
          chk("rsp_valid_held", 32'(rsp_valid), 1);
          chk("rsp_res_stable", 32'(rsp_res), 32'(prev_res));
        end
        chk("req_ready", 32'(req_ready), 32'((acc - pops) < DEPTH));
        chk("busy", 32'(busy), 32'(in_win || in_resp || (acc - pops) > 0));
        if (req_valid && req_ready) acc++;
        if (rsp_valid && rsp_ready) begin
          chk("rsp_expected", 32'(res_q.size() != 0), 1);
          if (res_q.size() != 0) chk("rsp_res", 32'(rsp_res), 32'(res_q.pop_front()));
          last_rsp = rsp_res;
          if (acc - done > 1) expect_start = cyc + 2;
          done++;
          in_resp = 0;
        end
        prev_ce = ce; prev_rv = rsp_valid; prev_rr = rsp_ready; prev_res = rsp_res;
      end
    end
  end

  // ---------------- response-side driver ----------------
  int rr_mode = 0;
  bit rr_val  = 1'b1;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (rr_mode == 1) ? ($urandom_range(0, 2) != 0) : rr_val;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input op_t o);
    req_opa = o.opa; req_opb = o.opb; req_mode = o.mode; req_cmd = o.cmd;
    req_cin = o.cin; req_split = o.split; req_gap = o.gap;
  endtask

  task automatic send(input op_t o);
    bit got = 0;
    int n = 0;
    drive(o);
    req_valid = 1'b1;
    while (!got && n < 2000) begin
      @(negedge clk);
      if (req_ready) begin
        trace_q.push_back(o);
        res_q.push_back(alu_f(o.opa, o.opb, o.mode, o.cmd, o.cin));
        got = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("send_accept_timeout", 32'(got), 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (res_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'(res_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic op_t mk(input int a, input int b, input bit m, input int c, input bit ci,
                             input bit sp, input int g);
    op_t o;
    o.opa = DW'(a); o.opb = DW'(b); o.mode = m; o.cmd = CW'(c); o.cin = ci;
    o.split = sp; o.gap = 4'(g);
    return o;
  endfunction

  function automatic op_t rand_op();
    return mk(int'($urandom), int'($urandom), 1'($urandom), int'($urandom), 1'($urandom),
              1'($urandom), ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 3)));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ce", 32'(ce), 0);
    chk("reset_inp_valid", 32'(inp_valid), 0);
    chk("reset_opa_opb", 32'({opa, opb}), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_res", 32'(rsp_res), 0);
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single non-split ADD
    send(mk('h0F, 'h01, 1, 0, 0, 0, 0));
    drain();
    chk("add_result", 32'(last_rsp), 32'h0010);

    // split with gap 3
    send(mk('hA5, 'h3C, 0, 5, 1, 1, 3));
    drain();

    // response held off for 10 cycles with a second op queued
    rr_val = 1'b0;
    send(mk('h12, 'h34, 1, 2, 1, 0, 0));
    send(mk('h56, 'h78, 0, 9, 0, 1, 1));
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("resp_reached", 32'(rsp_valid), 1);
    repeat (10) @(posedge clk);
    #1 rr_val = 1'b1;
    drain();

    // back-to-back pushes with responses blocked: holding register plus DEPTH FIFO slots
    rr_val = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(mk(i, i + 7, 1, 0, i[0], 0, 0));
    drive(mk('hEE, 'h11, 0, 3, 0, 0, 0));
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_req_ready_low", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 rr_val = 1'b1;
    send(mk('hEE, 'h11, 0, 3, 0, 0, 0));
    drain();

    // longest split window followed by a gap-0 split
    send(mk('hC3, 'h3C, 1, 1, 1, 1, 15));
    send(mk('h81, 'h7E, 0, 6, 0, 1, 0));
    drain();

    // reset in WAIT with the FIFO holding three requests
    send(mk('h01, 'h02, 1, 0, 0, 1, 15));
    for (int i = 0; i < 3; i++) send(mk('h40 + i, i, 1, 0, 0, 0, 0));
    n = 0;
    do begin @(negedge clk); n++; end while (inp_valid != 2'b10 && n < 100);
    chk("reached_beat_b", 32'(inp_valid), 32'(2'b10));
    @(negedge clk);
    chk("in_wait_before_reset", 32'({ce, inp_valid}), 32'(3'b100));
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 0);
    chk("post_reset_ce", 32'(ce), 0);
    chk("post_reset_req_ready", 32'(req_ready), 1);
    chk("post_reset_busy", 32'(busy), 0);
    repeat (20) @(posedge clk);
    #1;

    // randomized traffic with random back-pressure
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(rand_op());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end
    drain();
    rr_mode = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_busy", 32'(busy), 0);
    chk("final_rsp_valid", 32'(rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    failures++;
    $display("FAIL watchdog cycles=60000 limit=60000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
